systolic_ctrl: RTL and testbench

Weight-stationary sequencer for the ROWS×COLS PE array.
- Accepts one matmul job at a time over a valid/ready command port.
- Streams bottom-row-first weights from the weight buffer into the array's background registers.
- Pulses each row's switch in step with that row's first valid input.
- Drives row-skewed input reads and valids, and flags when each column's psum leaves the array's south edge.

---
 rtl/sa_ctrl_pkg.sv | 15 +
 rtl/sa_skew.sv | 40 ++++
 rtl/systolic_ctrl.sv | 153 +++++++++++++++
 tb/tb_systolic_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_ctrl_pkg.sv
// Shared types and width helpers for the weight-stationary systolic array sequencer.
package sa_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DONE} sa_ctrl_state_t;

    // Counter must hold the longest phase, L = K_MAX + ROWS + COLS.
    function automatic int cnt_width(input int k_max, input int rows, input int cols);
        return $clog2(k_max + rows + cols + 1);
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sa_skew.sv
// Window decoder for the skewed wavefront: row r is live for s in [r+1, r+K],
// column c's psum leaves the south edge for s in [ROWS+c+1, ROWS+c+K].
module sa_skew
    import sa_ctrl_pkg::*;
#(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int CNT_W = 5,
    parameter int K_W   = 5
) (
    input  logic             active,
    input  logic [CNT_W-1:0] s,
    input  logic [K_W-1:0]   k,
    output logic [ROWS-1:0]  row_valid,
    output logic [ROWS-1:0]  row_switch,
    output logic [COLS-1:0]  col_valid
);

    localparam int W = CNT_W + 1;

    logic [W-1:0] s_w;
    logic [W-1:0] k_w;

    assign s_w = W'(s);
    assign k_w = W'(k);

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            localparam logic [W-1:0] LO = W'(gi + 1);
            assign row_valid[gi]  = active && (s_w >= LO) && (s_w < LO + k_w);
            assign row_switch[gi] = active && (s_w == LO) && (k_w != '0);
        end
        for (gi = 0; gi < COLS; gi++) begin : g_col
            localparam logic [W-1:0] LO = W'(ROWS + gi + 1);
            assign col_valid[gi] = active && (s_w >= LO) && (s_w < LO + k_w);
        end
    endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// Weight-stationary sequencer: loads weights bottom-row-first, then streams skewed inputs.
// Optional SYSTOLIC_CTRL_PERF_EN adds busy-cycle and job counters.
module systolic_ctrl
    import sa_ctrl_pkg::*;
#(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int K_MAX = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     cmd_valid,
    output logic                                     cmd_ready,
    input  logic [$clog2(K_MAX+1)-1:0]               cmd_num_vec,
    input  logic                                     cmd_reuse_w,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     wbuf_rd_en,
    output logic [addr_width(ROWS)-1:0]              wbuf_rd_addr,
    output logic [COLS-1:0]                          sa_accept_w,
    output logic                                     ibuf_rd_en,
    output logic [addr_width(K_MAX)-1:0]             ibuf_rd_addr,
    output logic [ROWS-1:0]                          sa_valid,
    output logic [ROWS-1:0]                          sa_switch,
    output logic [COLS-1:0]                          out_valid
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [31:0]                              perf_busy_cycles,
    output logic [15:0]                              perf_jobs
`endif
);

    localparam int KW    = $clog2(K_MAX + 1);
    localparam int CNT_W = cnt_width(K_MAX, ROWS, COLS);
    localparam int WA    = addr_width(ROWS);
    localparam int IA    = addr_width(K_MAX);

    sa_ctrl_state_t   state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [KW-1:0]    k_reg, k_next;
    logic [KW-1:0]    k_clamped;
    logic [CNT_W-1:0] stream_last;

    assign k_clamped   = (cmd_num_vec > KW'(K_MAX)) ? KW'(K_MAX) : cmd_num_vec;
    assign stream_last = CNT_W'(k_reg) + CNT_W'(ROWS + COLS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            k_reg     <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            k_reg     <= k_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        k_next       = k_reg;
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        wbuf_rd_en   = 1'b0;
        wbuf_rd_addr = '0;
        sa_accept_w  = '0;
        ibuf_rd_en   = 1'b0;
        ibuf_rd_addr = '0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                cnt_next  = '0;
                if (cmd_valid) begin
                    k_next = k_clamped;
                    if (!cmd_reuse_w)
                        state_next = LOAD_W;
                    else if (k_clamped == '0)
                        state_next = DONE;
                    else
                        state_next = STREAM;
                end
            end
            LOAD_W: begin
                // Row ROWS-1 is fetched first so it sinks to the bottom of the array.
                if (cnt_reg < CNT_W'(ROWS)) begin
                    wbuf_rd_en   = 1'b1;
                    wbuf_rd_addr = WA'(CNT_W'(ROWS - 1) - cnt_reg);
                end
                if (cnt_reg != '0)
                    sa_accept_w = '1;
                if (cnt_reg == CNT_W'(ROWS)) begin
                    cnt_next   = '0;
                    state_next = (k_reg == '0) ? DONE : STREAM;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STREAM: begin
                if (cnt_reg < CNT_W'(k_reg)) begin
                    ibuf_rd_en   = 1'b1;
                    ibuf_rd_addr = IA'(cnt_reg);
                end
                if (cnt_reg == stream_last) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                done       = 1'b1;
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    sa_skew #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .CNT_W (CNT_W),
        .K_W   (KW)
    ) u_skew (
        .active     (state_reg == STREAM),
        .s          (cnt_reg),
        .k          (k_reg),
        .row_valid  (sa_valid),
        .row_switch (sa_switch),
        .col_valid  (out_valid)
    );

`ifdef SYSTOLIC_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_cycles <= '0;
            perf_jobs        <= '0;
        end else begin
            if (busy && (perf_busy_cycles != '1))
                perf_busy_cycles <= perf_busy_cycles + 1'b1;
            if (done && (perf_jobs != '1))
                perf_jobs <= perf_jobs + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl (ROWS=COLS=2, K_MAX=16); honours SYSTOLIC_CTRL_PERF_EN.
module tb_systolic_ctrl;

    localparam int ROWS  = 2;
    localparam int COLS  = 2;
    localparam int K_MAX = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_num_vec;
    logic       cmd_reuse_w;
    logic       busy;
    logic       done;
    logic       wbuf_rd_en;
    logic [0:0] wbuf_rd_addr;
    logic [1:0] sa_accept_w;
    logic       ibuf_rd_en;
    logic [3:0] ibuf_rd_addr;
    logic [1:0] sa_valid;
    logic [1:0] sa_switch;
    logic [1:0] out_valid;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_busy_cycles;
    logic [15:0] perf_jobs;
`endif

    always #5 clk = ~clk;

    systolic_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_MAX(K_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_num_vec  (cmd_num_vec),
        .cmd_reuse_w  (cmd_reuse_w),
        .busy         (busy),
        .done         (done),
        .wbuf_rd_en   (wbuf_rd_en),
        .wbuf_rd_addr (wbuf_rd_addr),
        .sa_accept_w  (sa_accept_w),
        .ibuf_rd_en   (ibuf_rd_en),
        .ibuf_rd_addr (ibuf_rd_addr),
        .sa_valid     (sa_valid),
        .sa_switch    (sa_switch),
        .out_valid    (out_valid)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .perf_busy_cycles (perf_busy_cycles),
        .perf_jobs        (perf_jobs)
`endif
    );

    typedef struct packed {
        logic       cmd_ready;
        logic       busy;
        logic       done;
        logic       wbuf_rd_en;
        logic [0:0] wbuf_rd_addr;
        logic [1:0] sa_accept_w;
        logic       ibuf_rd_en;
        logic [3:0] ibuf_rd_addr;
        logic [1:0] sa_valid;
        logic [1:0] sa_switch;
        logic [1:0] out_valid;
    } obs_t;

    typedef struct {
        int k;
        bit reuse;
        bit keep;
        int exp_done;
        int exp_ibuf;
        int exp_wbuf;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int job_id = 0;

    function automatic obs_t idle_obs();
        obs_t o;
        o = '0;
        o.cmd_ready = 1'b1;
        return o;
    endfunction

    // Job timeline from accept cycle 0, derived directly from the phase lengths.
    function automatic int done_cycle(input int k, input bit reuse);
        int kc;
        int ld;
        kc = (k > K_MAX) ? K_MAX : k;
        ld = reuse ? 0 : ROWS + 1;
        return (kc == 0) ? 1 + ld : 1 + ld + kc + ROWS + COLS;
    endfunction

    function automatic obs_t model(input int t, input int k, input bit reuse);
        obs_t o;
        int kc;
        int ld;
        int dt;
        int l;
        int s;
        o  = '0;
        kc = (k > K_MAX) ? K_MAX : k;
        ld = reuse ? 0 : ROWS + 1;
        dt = done_cycle(k, reuse);
        if (t < 1 || t > dt) return idle_obs();
        o.busy = 1'b1;
        if (t == dt) begin
            o.done = 1'b1;
            return o;
        end
        if (t <= ld) begin
            l = t - 1;
            if (l < ROWS) begin
                o.wbuf_rd_en   = 1'b1;
                o.wbuf_rd_addr = 1'(ROWS - 1 - l);
            end
            if (l >= 1) o.sa_accept_w = 2'b11;
            return o;
        end
        s = t - 1 - ld;
        if (s < kc) begin
            o.ibuf_rd_en   = 1'b1;
            o.ibuf_rd_addr = 4'(s);
        end
        for (int r = 0; r < ROWS; r++) begin
            if (s >= r + 1 && s <= r + kc) o.sa_valid[r] = 1'b1;
            if (s == r + 1) o.sa_switch[r] = 1'b1;
        end
        for (int c = 0; c < COLS; c++)
            if (s >= ROWS + c + 1 && s <= ROWS + c + kc) o.out_valid[c] = 1'b1;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.cmd_ready    = cmd_ready;
        o.busy         = busy;
        o.done         = done;
        o.wbuf_rd_en   = wbuf_rd_en;
        o.wbuf_rd_addr = wbuf_rd_addr;
        o.sa_accept_w  = sa_accept_w;
        o.ibuf_rd_en   = ibuf_rd_en;
        o.ibuf_rd_addr = ibuf_rd_addr;
        o.sa_valid     = sa_valid;
        o.sa_switch    = sa_switch;
        o.out_valid    = out_valid;
        return o;
    endfunction

    task automatic check_obs(input string name, input int t, input obs_t exp);
        obs_t got;
        got = sample();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s job=%0d t=%0d got=%h required=%h", name, job_id, t, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s job=%0d got=%0d required=%0d", name, job_id, got, exp);
        end
    endtask

    // Called at the start of an IDLE cycle; returns at the start of the cycle after done.
    task automatic run_job(input int k, input bit reuse, input bit keep,
                           output int obs_done, output int n_ibuf, output int n_wbuf);
        int dt;
        dt          = done_cycle(k, reuse);
        obs_done    = -1;
        n_ibuf      = 0;
        n_wbuf      = 0;
        cmd_valid   = 1'b1;
        cmd_num_vec = 5'(k);
        cmd_reuse_w = reuse;
        for (int t = 0; t <= dt; t++) begin
            @(negedge clk);
            check_obs("cycle", t, model(t, k, reuse));
            if (done && obs_done < 0) obs_done = t;
            if (ibuf_rd_en) n_ibuf++;
            if (wbuf_rd_en) n_wbuf++;
            @(posedge clk);
            #1;
            if (t == 0 && !keep) cmd_valid = 1'b0;
        end
        if (!keep) cmd_valid = 1'b0;
        $display("job %0d k=%0d reuse=%0d done_at=%0d ibuf_reads=%0d wbuf_reads=%0d",
                 job_id, k, reuse, obs_done, n_ibuf, n_wbuf);
        job_id++;
    endtask

    vec_t vecs[7];

    initial begin
        int od;
        int ni;
        int nw;

        vecs[0] = '{k: 3,  reuse: 1'b0, keep: 1'b0, exp_done: 11, exp_ibuf: 3,  exp_wbuf: 2};
        vecs[1] = '{k: 1,  reuse: 1'b1, keep: 1'b0, exp_done: 6,  exp_ibuf: 1,  exp_wbuf: 0};
        vecs[2] = '{k: 0,  reuse: 1'b1, keep: 1'b0, exp_done: 1,  exp_ibuf: 0,  exp_wbuf: 0};
        vecs[3] = '{k: 0,  reuse: 1'b0, keep: 1'b0, exp_done: 4,  exp_ibuf: 0,  exp_wbuf: 2};
        vecs[4] = '{k: 31, reuse: 1'b0, keep: 1'b1, exp_done: 24, exp_ibuf: 16, exp_wbuf: 2};
        vecs[5] = '{k: 31, reuse: 1'b0, keep: 1'b0, exp_done: 24, exp_ibuf: 16, exp_wbuf: 2};
        vecs[6] = '{k: 16, reuse: 1'b1, keep: 1'b0, exp_done: 21, exp_ibuf: 16, exp_wbuf: 0};

        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_num_vec = '0;
        cmd_reuse_w = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_obs("reset", 0, idle_obs());
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i].k, vecs[i].reuse, vecs[i].keep, od, ni, nw);
            check_int("done_cycle", od, vecs[i].exp_done);
            check_int("ibuf_reads", ni, vecs[i].exp_ibuf);
            check_int("wbuf_reads", nw, vecs[i].exp_wbuf);
`ifdef SYSTOLIC_CTRL_PERF_EN
            if (i == 0) begin
                check_int("perf_busy_cycles", int'(perf_busy_cycles), 11);
                check_int("perf_jobs", int'(perf_jobs), 1);
            end
`endif
        end

        // Reset asserted for two cycles in the middle of STREAM.
        cmd_valid   = 1'b1;
        cmd_num_vec = 5'd3;
        cmd_reuse_w = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            check_obs("pre_reset", t, model(t, 3, 1'b0));
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_obs("mid_reset", 0, idle_obs());
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_obs("post_reset", 0, idle_obs());
`ifdef SYSTOLIC_CTRL_PERF_EN
        check_int("perf_busy_clear", int'(perf_busy_cycles), 0);
        check_int("perf_jobs_clear", int'(perf_jobs), 0);
`endif
        @(posedge clk);
        #1;
        job_id++;

        for (int i = 0; i < 25; i++) begin
            int k;
            bit reuse;
            k     = int'($urandom_range(0, 20));
            reuse = 1'($urandom_range(0, 1));
            run_job(k, reuse, 1'b0, od, ni, nw);
            check_int("rand_done", od, done_cycle(k, reuse));
            check_int("rand_ibuf", ni, (k > K_MAX) ? K_MAX : k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
